// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and defaults for the dmem responder slice.
//   dmem_state_e  : responder state (INIT sweep, RUN serving the core)
//   DMEM_ADDR_W   : default word-address width
//   DMEM_DATA_W   : default data word width
//   ptr_width()   : width of the init sweep pointer for a given depth
package dmem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dmem_state_e;

    localparam int unsigned DMEM_ADDR_W = 12;
    localparam int unsigned DMEM_DATA_W = 32;

    // ceil(log2(depth)), never below 1 so a one-word memory still gets a pointer bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? int'($clog2(depth)) : 1;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: processor dmem port bundle.
//   address_dmem [ADDR_W] : word address        (master -> slave)
//   data         [DATA_W] : write data          (master -> slave)
//   wren                  : 1 write, 0 read     (master -> slave)
//   q_dmem       [DATA_W] : registered read data (slave -> master)
//   ready                 : init sweep finished  (slave -> master)
//   addr_err              : out-of-range pulse   (slave -> master)
//   rd_count/wr_count     : access counters, only with DMEM_TRACE_EN
interface dmem_responder_if
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W
) ();

    logic [ADDR_W-1:0] address_dmem;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic [DATA_W-1:0] q_dmem;
    logic              ready;
    logic              addr_err;
`ifdef DMEM_TRACE_EN
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;
`endif

    modport master (
        output address_dmem, data, wren,
`ifdef DMEM_TRACE_EN
        input  rd_count, wr_count,
`endif
        input  q_dmem, ready, addr_err
    );

    modport slave (
        input  address_dmem, data, wren,
`ifdef DMEM_TRACE_EN
        output rd_count, wr_count,
`endif
        output q_dmem, ready, addr_err
    );

endinterface

// File: rtl/dmem_ram_core.sv
// dmem_ram_core: single-port synchronous word array, write-first, 1-cycle read.
//   clock, reset : clock and async active-high reset (read register only)
//   we           : write wdata to mem[addr]
//   clr_rd       : force the read register to zero this cycle
//   addr, wdata  : word index and write data
//   rdata        : registered read data
module dmem_ram_core #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned PTR_W  = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic              clr_rd,
    input  logic [PTR_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage has no reset; the responder's init sweep clears it.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: write-first so a write is echoed on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (clr_rd) begin
            rdata <= '0;
        end else if (we) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder on the core's dmem port.
//   clock  : dmem clock, all state on rising edge
//   reset  : asynchronous, active-high; restarts the clearing sweep
//   bus    : dmem_responder_if.slave (address_dmem/data/wren in,
//            q_dmem/ready/addr_err out, rd_count/wr_count with DMEM_TRACE_EN)
// After reset every word is written with INIT_VALUE (DEPTH cycles), then
// ready rises and each cycle is a read or write access with 1-cycle latency.
// Optional feature macro: DMEM_TRACE_EN adds honoured read/write counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned        ADDR_W     = DMEM_ADDR_W,
    parameter int unsigned        DATA_W     = DMEM_DATA_W,
    parameter int unsigned        DEPTH      = 4096,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    dmem_responder_if.slave   bus
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);

    dmem_state_e        state;
    logic [PTR_W-1:0]   init_ptr;
    logic               ready_q;
    logic               addr_err_q;

    logic               in_range;
    logic               ram_we;
    logic               ram_clr;
    logic [PTR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]  ram_wdata;

    // Range check and mux between the init sweep and the processor port.
    always_comb begin
        in_range  = 32'(bus.address_dmem) < 32'(DEPTH);
        ram_we    = bus.wren & in_range;
        ram_clr   = ~in_range;
        ram_addr  = PTR_W'(bus.address_dmem);
        ram_wdata = bus.data;
        if (state == INIT) begin
            ram_we    = 1'b1;
            ram_clr   = 1'b1;
            ram_addr  = init_ptr;
            ram_wdata = INIT_VALUE;
        end
    end

    dmem_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_ram (
        .clock  (clock),
        .reset  (reset),
        .we     (ram_we),
        .clr_rd (ram_clr),
        .addr   (ram_addr),
        .wdata  (ram_wdata),
        .rdata  (bus.q_dmem)
    );

`ifdef DMEM_TRACE_EN
    logic [31:0] rd_count_q;
    logic [31:0] wr_count_q;
`endif

    // Responder FSM: sweep every word once, then serve the processor.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            init_ptr   <= '0;
            ready_q    <= 1'b0;
            addr_err_q <= 1'b0;
`ifdef DMEM_TRACE_EN
            rd_count_q <= '0;
            wr_count_q <= '0;
`endif
        end else begin
            unique case (state)
                INIT: begin
                    addr_err_q <= 1'b0;
                    if (init_ptr == PTR_W'(DEPTH - 1)) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        init_ptr <= init_ptr + PTR_W'(1);
                    end
                end
                RUN: begin
                    addr_err_q <= ~in_range;
`ifdef DMEM_TRACE_EN
                    if (in_range && bus.wren) begin
                        wr_count_q <= wr_count_q + 32'd1;
                    end
                    if (in_range && !bus.wren) begin
                        rd_count_q <= rd_count_q + 32'd1;
                    end
`endif
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.addr_err = addr_err_q;
`ifdef DMEM_TRACE_EN
    assign bus.rd_count = rd_count_q;
    assign bus.wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven bench for dmem_responder with DEPTH=16.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 16;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    dmem_responder_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    dmem_responder #(
        .ADDR_W     (12),
        .DATA_W     (32),
        .DEPTH      (DEPTH),
        .INIT_VALUE (32'h0)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wren;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] exp_q;
        logic        exp_err;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [11:0] a, input logic [31:0] d);
        bus.wren         = w;
        bus.address_dmem = a;
        bus.data         = d;
    endtask

    // Count edges until ready; it must rise exactly DEPTH edges after release.
    task automatic wait_ready(input string name);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 4 * DEPTH) begin
            step();
            n++;
            if (bus.ready) seen = 1'b1;
            else check({name, "_q_during_init"}, bus.q_dmem, 32'h0);
        end
        check(name, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        vecs[0]  = '{1'b1, 12'd5,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0};
        vecs[1]  = '{1'b0, 12'd5,  32'h0,         32'h7FFF_FFFF, 1'b0};
        vecs[2]  = '{1'b1, 12'd9,  32'h8000_0000, 32'h8000_0000, 1'b0};
        vecs[3]  = '{1'b0, 12'd9,  32'h0,         32'h8000_0000, 1'b0};
        vecs[4]  = '{1'b0, 12'd3,  32'h0,         32'h0,         1'b0};
        vecs[5]  = '{1'b0, 12'd0,  32'h0,         32'h0,         1'b0};
        vecs[6]  = '{1'b0, 12'd15, 32'h0,         32'h0,         1'b0};
        vecs[7]  = '{1'b0, 12'd20, 32'h0,         32'h0,         1'b1};
        vecs[8]  = '{1'b0, 12'd9,  32'h0,         32'h8000_0000, 1'b0};
        vecs[9]  = '{1'b1, 12'd20, 32'h1234_5678, 32'h0,         1'b1};
        vecs[10] = '{1'b0, 12'd4,  32'h0,         32'h0,         1'b0};
        vecs[11] = '{1'b1, 12'd9,  32'h1111_1111, 32'h1111_1111, 1'b0};
        vecs[12] = '{1'b1, 12'd9,  32'h2222_2222, 32'h2222_2222, 1'b0};
        vecs[13] = '{1'b0, 12'd9,  32'h0,         32'h2222_2222, 1'b0};
        vecs[14] = '{1'b1, 12'd15, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0};
        vecs[15] = '{1'b0, 12'd15, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vecs[16] = '{1'b1, 12'd1,  32'h0000_0003, 32'h0000_0003, 1'b0};
        vecs[17] = '{1'b0, 12'd1,  32'h0,         32'h0000_0003, 1'b0};

        // Reset state; processor writes during the sweep must be ignored.
        rst = 1'b1;
        drive(1'b1, 12'd3, 32'hDEAD_BEEF);
        step();
        step();
        check("rst_q", bus.q_dmem, 32'h0);
        check("rst_ready", 32'(bus.ready), 32'h0);
        check("rst_err", 32'(bus.addr_err), 32'h0);
`ifdef DMEM_TRACE_EN
        check("rst_rd_count", bus.rd_count, 32'h0);
        check("rst_wr_count", bus.wr_count, 32'h0);
`endif
        rst = 1'b0;
        wait_ready("init_len");

        // Main vector table: expectation is the output after the presenting edge.
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].wren, vecs[i].addr, vecs[i].data);
            step();
            check($sformatf("vec%0d_q", i), bus.q_dmem, vecs[i].exp_q);
            check($sformatf("vec%0d_err", i), 32'(bus.addr_err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_ready", i), 32'(bus.ready), 32'h1);
        end
`ifdef DMEM_TRACE_EN
        check("rd_count", bus.rd_count, 32'd10);
        check("wr_count", bus.wr_count, 32'd6);
`endif

        // Reset mid-RUN: async clear of outputs, then a full re-sweep.
        drive(1'b0, 12'd1, 32'h0);
        rst = 1'b1;
        #1;
        check("midrun_rst_q", bus.q_dmem, 32'h0);
        check("midrun_rst_ready", 32'(bus.ready), 32'h0);
`ifdef DMEM_TRACE_EN
        check("midrun_rd_count", bus.rd_count, 32'h0);
`endif
        step();
        rst = 1'b0;

        // Reset again five cycles into the sweep: it restarts from zero.
        for (int i = 0; i < 5; i++) step();
        check("midinit_ready", 32'(bus.ready), 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready("resweep_len");

        drive(1'b0, 12'd1, 32'h0);
        step();
        check("resweep_rd1", bus.q_dmem, 32'h0);
        drive(1'b0, 12'd9, 32'h0);
        step();
        check("resweep_rd9", bus.q_dmem, 32'h0);
        drive(1'b0, 12'd15, 32'h0);
        step();
        check("resweep_rd15", bus.q_dmem, 32'h0);
`ifdef DMEM_TRACE_EN
        check("resweep_rd_count", bus.rd_count, 32'd3);
        check("resweep_wr_count", bus.wr_count, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
